ifetch_stage: RTL



---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/ifetch_stage_ifid_reg.sv | 39 +++
 rtl/ifetch_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared constants and the IF/ID bundle type for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

    localparam int          PC_W     = 32;
    localparam logic [31:0] PC_INCR  = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_stage_ifid_reg.sv
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register. Flush inserts a bubble while keeping
//               the pc/pc4 fields; load captures a new fetch; otherwise holds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_reg
    import ifetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  flush,
    input  ifid_t data,
    output ifid_t q
);

    // Flush wins over load so a redirect squashes the word being fetched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q.instr <= NOP_INSTR;
            q.pc    <= '0;
            q.pc4   <= '0;
            q.valid <= 1'b0;
        end else if (flush) begin
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_stage.sv
// ============================================================================
// Module      : ifetch_stage
// Description : Instruction-fetch front end. Holds the PC, addresses the
//               combinational instruction ROM and fills the IF/ID register.
//               Handles stall and branch/jump redirect.
//               Optional macro IFETCH_ALIGN_CHECK_EN enables the sticky
//               misaligned-redirect flag (misalign_err); otherwise it is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        misalign_err
);

    logic [PC_W-1:0] r_pc;
    ifid_t           w_fetch;
    ifid_t           w_ifid;

    // The ROM address comes straight from the PC flop
    assign imem_addr = r_pc;

    // PC register: redirect beats stall; targets are forced word-aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= {RESET_PC[31:2], 2'b00};
        end else if (redirect) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (!stall) begin
            r_pc <= r_pc + PC_INCR;
        end
    end

    // Bundle describing the word returned for the current PC
    always_comb begin
        w_fetch       = '0;
        w_fetch.instr = imem_data;
        w_fetch.pc    = r_pc;
        w_fetch.pc4   = r_pc + PC_INCR;
        w_fetch.valid = 1'b1;
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .load  (!stall),
        .flush (redirect),
        .data  (w_fetch),
        .q     (w_ifid)
    );

    assign ifid_instr = w_ifid.instr;
    assign ifid_pc    = w_ifid.pc;
    assign ifid_pc4   = w_ifid.pc4;
    assign ifid_valid = w_ifid.valid;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_misalign;

    // Sticky flag: any accepted redirect with nonzero low bits sets it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    // Low target bits are only inspected by the alignment checker
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign misalign_err        = 1'b0;
`endif

endmodule

`default_nettype wire
